// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard path
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_e;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/hazard_wait_timer.sv
// rtl/hazard_wait_timer.sv - memory-wait cycle counter with terminal-count compare
module hazard_wait_timer #(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_inc,
    output logic o_at_max
);

    logic [WAIT_W-1:0] r_count;

    if (MAX_WAIT < 1 || MAX_WAIT >= (1 << WAIT_W)) begin : g_bad_max_wait
        $error("hazard_wait_timer: MAX_WAIT must be in 1..2^WAIT_W-1");
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= WAIT_W'(1);
        end else if (i_inc) begin
            r_count <= r_count + WAIT_W'(1);
        end
    end

    assign o_at_max = (r_count == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch / memory-wait pipeline sequencing controller
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 200,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] IDRs1_i,
    input  logic [REG_AW-1:0] IDRs2_i,
    input  logic              IDUseRs1_i,
    input  logic              IDUseRs2_i,
    input  logic              EXMemRead_i,
    input  logic [REG_AW-1:0] EXRd_i,
    input  logic              BranchTaken_i,
    input  logic              MemReq_i,
    input  logic              MemAck_i,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic              IDEXBubble_o,
    output logic              IFIDFlush_o,
    output logic              PipeStall_o,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0]  StallCycles_o,
    output logic [CNT_W-1:0]  BubbleCnt_o,
    output logic [CNT_W-1:0]  FlushCnt_o,
`endif
    output logic              MemTimeout_o
);

    hz_state_e r_state;
    logic      r_timeout;
    logic      w_mem_pending;
    logic      w_mstall;
    logic      w_lu;
    logic      w_at_max;
    logic      w_tmr_load;
    logic      w_tmr_clear;
    logic      w_tmr_inc;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_stall_ctrl: CNT_W must be at least 1");
    end

    assign w_mem_pending = MemReq_i & ~MemAck_i;
    assign w_mstall      = (r_state == HALT) | w_mem_pending;

    assign w_lu = EXMemRead_i & (EXRd_i != REG_AW'(REG_ZERO)) &
                  ((IDUseRs1_i & (EXRd_i == IDRs1_i)) |
                   (IDUseRs2_i & (EXRd_i == IDRs2_i)));

    assign w_tmr_load  = (r_state == RUN) & w_mem_pending;
    assign w_tmr_clear = (r_state == MEM_WAIT) & ~w_mem_pending;
    assign w_tmr_inc   = (r_state == MEM_WAIT) & w_mem_pending & ~w_at_max;

    hazard_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk    (clk_i),
        .i_rst_n  (rst_n_i),
        .i_clear  (w_tmr_clear),
        .i_load   (w_tmr_load),
        .i_inc    (w_tmr_inc),
        .o_at_max (w_at_max)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= RUN;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_pending) r_state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (!w_mem_pending) begin
                        r_state <= RUN;
                    end else if (w_at_max) begin
                        r_state   <= HALT;
                        r_timeout <= 1'b1;
                    end
                end
                HALT: begin
                    r_timeout <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Reset gates every output so a reset mid-stall leaves no residual bubble or flush
    always_comb begin
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        IDEXBubble_o = 1'b0;
        IFIDFlush_o  = 1'b0;
        PipeStall_o  = 1'b0;
        if (rst_n_i) begin
            if (w_mstall) begin
                PipeStall_o = 1'b1;
            end else if (w_lu) begin
                IDEXBubble_o = 1'b1;
            end else begin
                PCWrite_o   = 1'b1;
                IFIDWrite_o = 1'b1;
                IFIDFlush_o = BranchTaken_i;
            end
        end
    end

    assign MemTimeout_o = r_timeout;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (PipeStall_o && (r_stall_cnt != '1))   r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
            if (IDEXBubble_o && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            if (IFIDFlush_o && (r_flush_cnt != '1))   r_flush_cnt  <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign StallCycles_o = r_stall_cnt;
    assign BubbleCnt_o   = r_bubble_cnt;
    assign FlushCnt_o    = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              br_taken;
    logic              mem_req;
    logic              mem_ack;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_bubble;
    logic              ifid_flush;
    logic              pipe_stall;
    logic              mem_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeStall, MemTimeout}
    logic [5:0] obs;
    assign obs = {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_stall, mem_timeout};

    localparam logic [5:0] V_OFF   = 6'b000000;
    localparam logic [5:0] V_RUN   = 6'b110000;
    localparam logic [5:0] V_FLUSH = 6'b110100;
    localparam logic [5:0] V_LU    = 6'b001000;
    localparam logic [5:0] V_STALL = 6'b000010;
    localparam logic [5:0] V_HALT  = 6'b000011;

    hazard_stall_ctrl #(
        .REG_AW   (REG_AW),
        .WAIT_W   (8),
        .MAX_WAIT (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .IDRs1_i       (id_rs1),
        .IDRs2_i       (id_rs2),
        .IDUseRs1_i    (use_rs1),
        .IDUseRs2_i    (use_rs2),
        .EXMemRead_i   (ex_memread),
        .EXRd_i        (ex_rd),
        .BranchTaken_i (br_taken),
        .MemReq_i      (mem_req),
        .MemAck_i      (mem_ack),
        .PCWrite_o     (pc_write),
        .IFIDWrite_o   (ifid_write),
        .IDEXBubble_o  (idex_bubble),
        .IFIDFlush_o   (ifid_flush),
        .PipeStall_o   (pipe_stall),
`ifdef HAZ_PERF_CNT_EN
        .StallCycles_o (stall_cnt),
        .BubbleCnt_o   (bubble_cnt),
        .FlushCnt_o    (flush_cnt),
`endif
        .MemTimeout_o  (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // check at the falling edge, then advance past the next rising edge
    task automatic cyc(input string tag, input logic [5:0] exp);
        @(negedge clk);
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        ex_memread = 1'b0; ex_rd = '0; br_taken = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", V_OFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        br_taken = 1'b1;
        cyc("reset_gates_branch", V_OFF);
        br_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc("idle_run", V_RUN);

        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1;
        cyc("lu_rs1", V_LU);
        ex_rd = 5'd0; id_rs1 = 5'd0;
        cyc("lu_rd_zero", V_RUN);
        ex_rd = 5'd7; id_rs1 = 5'd3; use_rs1 = 1'b1; id_rs2 = 5'd7; use_rs2 = 1'b1;
        cyc("lu_rs2", V_LU);
        use_rs2 = 1'b0;
        cyc("lu_rs2_unused", V_RUN);
        ex_memread = 1'b0; use_rs2 = 1'b1;
        cyc("no_load_no_lu", V_RUN);

        idle_inputs();
        br_taken = 1'b1;
        cyc("branch_flush", V_FLUSH);
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; use_rs1 = 1'b1;
        cyc("branch_with_lu", V_LU);

        // memory wait: three cycles without ack, branch and load-use lose to stall
        mem_req = 1'b1; mem_ack = 1'b0;
        cyc("mwait_c0", V_STALL);
        idle_inputs();
        mem_req = 1'b1;
        cyc("mwait_c1", V_STALL);
        cyc("mwait_c2", V_STALL);
        mem_ack = 1'b1;
        cyc("mwait_ack", V_RUN);
        mem_req = 1'b0; mem_ack = 1'b0;
        cyc("after_ack_run", V_RUN);
        mem_req = 1'b1; mem_ack = 1'b1;
        cyc("same_cycle_ack", V_RUN);

        // abandoned access: stall drops when request goes away
        mem_req = 1'b1; mem_ack = 1'b0;
        cyc("abandon_c0", V_STALL);
        mem_req = 1'b0;
        br_taken = 1'b1;
        cyc("abandon_drop", V_FLUSH);
        br_taken = 1'b0;
        cyc("abandon_run", V_RUN);

        // timeout with MAX_WAIT=4: RUN cycle plus four MEM_WAIT cycles, then HALT
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) cyc($sformatf("tmo_wait_%0d", i), V_STALL);
        cyc("tmo_halt", V_HALT);
        mem_req = 1'b0; mem_ack = 1'b1;
        cyc("halt_sticky_ack", V_HALT);
        mem_ack = 1'b0; br_taken = 1'b1;
        cyc("halt_sticky_idle", V_HALT);
        br_taken = 1'b0;

        do_reset();
        cyc("post_halt_reset_run", V_RUN);

        // reset asserted mid-cycle while in MEM_WAIT
        mem_req = 1'b1; mem_ack = 1'b0;
        cyc("rst_mw_enter", V_STALL);
        chk("rst_mw_in_wait", V_STALL);
        rst_n = 1'b0;
        #1;
        chk("rst_mw_async_off", V_OFF);
        @(negedge clk);
        rst_n = 1'b1;
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        cyc("rst_mw_release_run", V_RUN);
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) cyc($sformatf("rst_tmo_wait_%0d", i), V_STALL);
        cyc("rst_tmo_halt", V_HALT);

`ifdef HAZ_PERF_CNT_EN
        idle_inputs();
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        assert (stall_cnt === 4'd15) else begin
            errors++;
            $error("FAIL perf_stall_sat observed %0d expected 15", stall_cnt);
        end
        checks++;
        assert (bubble_cnt === 4'd0) else begin
            errors++;
            $error("FAIL perf_bubble observed %0d expected 0", bubble_cnt);
        end
        checks++;
        assert (flush_cnt === 4'd0) else begin
            errors++;
            $error("FAIL perf_flush observed %0d expected 0", flush_cnt);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
